// File: rtl/ahb_resp_mux_pkg.sv
// Shared definitions for the AHB data-phase response mux and its
// built-in default slave: bus encodings, slot numbering, FSM states
// and the select-priority helper.
package ahb_resp_mux_pkg;

    // HTRANS transfer types
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Decoder slots; the last one is the unmapped region served internally
    localparam int         NSLOT        = 8;
    localparam logic [2:0] DEFAULT_SLOT = 3'd7;

    // Default-slave FSM states
    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    // Overlapping decoder regions resolve to the lowest set index;
    // no select at all lands on the default (unmapped) slot.
    function automatic logic [2:0] eff_select(input logic [7:0] hsel);
        logic [2:0] idx;
        idx = DEFAULT_SLOT;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (hsel[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_resp_mux_default_slave.sv
// Built-in default slave for the unmapped region. Answers active
// transfers with the two-cycle AHB ERROR response and counts how many
// ERROR responses it has started (saturating).
module ahb_default_slave
    import ahb_resp_mux_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL7_eff,
    input  logic [1:0]       HTRANS,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic             HRESP,
    output logic [CNT_W-1:0] ERR_CNT
);

    ds_state_t        state_reg;
    ds_state_t        state_next;
    logic             active;
    logic             start;
    logic             hreadyout_reg;
    logic             hresp_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Decode whether the sampled address phase is a real (NONSEQ/SEQ)
    // transfer to the unmapped region, and pick the next FSM state.
    always_comb begin
        active     = 1'b0;
        state_next = DS_IDLE;
        case (HTRANS)
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            default:                   active = 1'b0;
        endcase
        start = HREADY && HSEL7_eff && active;
        case (state_reg)
            DS_IDLE: state_next = start ? DS_ERR1 : DS_IDLE;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = start ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    // State, registered bus outputs and the saturating ERROR counter.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg     <= DS_IDLE;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= HRESP_OKAY;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            // Wait state only in ERR1; ERROR held through ERR1 and ERR2
            hreadyout_reg <= (state_next != DS_ERR1);
            hresp_reg     <= (state_next == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;
            if ((state_next == DS_ERR1) && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign HREADYOUT = hreadyout_reg;
    assign HRESP     = hresp_reg;
    assign ERR_CNT   = cnt_reg;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite data-phase response mux. Registers the prioritised decoder
// select at the end of each address phase and returns the selected
// slave's HRDATA/HREADY/HRESP to the single master. Slot 7 is served by
// the built-in default slave.
module ahb_resp_mux
    import ahb_resp_mux_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NSLV   = 7,
    parameter int CNT_W  = 8
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [7:0]             HSEL,
    input  logic [1:0]             HTRANS,
    input  logic [NSLV*DATA_W-1:0] HRDATA_S,
    input  logic [NSLV-1:0]        HREADYOUT_S,
    input  logic [NSLV-1:0]        HRESP_S,
    output logic [DATA_W-1:0]      HRDATA,
    output logic                   HREADY,
    output logic                   HRESP,
    output logic [CNT_W-1:0]       ERR_CNT
);

    logic [2:0]        sel_eff;
    logic [2:0]        sel_q;
    logic              ds_hreadyout;
    logic              ds_hresp;
    logic [DATA_W-1:0] rdata_slot [NSLOT];
    logic              ready_slot [NSLOT];
    logic              resp_slot  [NSLOT];

    assign sel_eff = eff_select(HSEL);

    // Capture the data-phase owner whenever the current transfer completes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q <= DEFAULT_SLOT;
        end else if (HREADY) begin
            sel_q <= sel_eff;
        end
    end

    // Flatten external slaves and the default slave into one 8-slot table;
    // slots beyond the external slaves are answered by the default slave.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        if (gi < NSLV) begin : g_ext
            assign rdata_slot[gi] = HRDATA_S[gi*DATA_W +: DATA_W];
            assign ready_slot[gi] = HREADYOUT_S[gi];
            assign resp_slot[gi]  = HRESP_S[gi];
        end else begin : g_dflt
            assign rdata_slot[gi] = '0;
            assign ready_slot[gi] = ds_hreadyout;
            assign resp_slot[gi]  = ds_hresp;
        end
    end

    assign HRDATA = rdata_slot[sel_q];
    assign HREADY = ready_slot[sel_q];
    assign HRESP  = resp_slot[sel_q];

    ahb_default_slave #(
        .CNT_W (CNT_W)
    ) u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL7_eff (sel_eff == DEFAULT_SLOT),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HREADYOUT (ds_hreadyout),
        .HRESP     (ds_hresp),
        .ERR_CNT   (ERR_CNT)
    );

endmodule
